// File: rtl/fpu_pkg.sv
// Shared FPU types and constants used by the fsqrt datapath and its arbiter.
package fpu_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_ONE     = 32'h3F800000;
  localparam fp32_t FP_POS_INF = 32'h7F800000;

  // Wide enough for the largest supported requester count (8).
  localparam int TAG_W = 3;

  typedef struct packed {
    fp32_t            y;
    logic             ovf;
    logic             udf;
    logic [TAG_W-1:0] tag;
    logic             valid;
  } sqrt_stage_t;

endpackage

// File: rtl/fsqrt.sv
// Combinational single-precision square root, round-to-nearest-even.
// Denormal operands flush to a signed zero and raise udf; an infinite result raises ovf.
module fsqrt
  import fpu_pkg::*;
(
  input  fp32_t x,
  output fp32_t y,
  output logic  ovf,
  output logic  udf
);

  localparam logic [7:0] BIAS = FP_ONE[30:23];
  localparam fp32_t      QNAN = 32'h7FC00000;

  logic [49:0] radicand;
  logic [27:0] rem;
  logic [27:0] trial;
  logic [24:0] root;
  logic [23:0] rounded;
  logic [7:0]  expOut;
  logic        roundUp;

  // An odd biased exponent means an even unbiased one, so the significand is
  // shifted one place less; the 25-bit root then carries one rounding bit.
  always_comb begin
    radicand = x[23] ? {2'b01, x[22:0], 25'b0} : {1'b1, x[22:0], 26'b0};
    rem      = '0;
    root     = '0;
    trial    = '0;
    for (int i = 24; i >= 0; i--) begin
      rem   = {rem[25:0], radicand[2*i +: 2]};
      trial = {1'b0, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[23:0], 1'b1};
      end else begin
        root = {root[23:0], 1'b0};
      end
    end
    roundUp = root[0] & ((rem != '0) | root[1]);
    rounded = root[24:1] + {23'b0, roundUp};
    expOut  = 8'(({1'b0, x[30:23]} + {1'b0, BIAS}) >> 1);

    y   = {1'b0, 31'({expOut - 8'd1, 23'b0} + {7'b0, rounded})};
    ovf = 1'b0;
    udf = 1'b0;
    if (x[30:23] == 8'hFF && x[22:0] != '0) begin
      y = QNAN;
    end else if (x[30:23] == 8'h00) begin
      y   = {x[31], 31'b0};
      udf = (x[22:0] != '0);
    end else if (x[31]) begin
      y = QNAN;
    end else if (x[30:23] == 8'hFF) begin
      y   = FP_POS_INF;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant.sv
// Round-robin picker: first eligible index at or after ptr, wrapping modulo NREQ.
module rr_grant #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  // Scan from the farthest offset back to ptr so the nearest eligible index wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (eligible[(int'(ptr) + off) % NREQ]) begin
        winner = IDX_W'((int'(ptr) + off) % NREQ);
        found  = 1'b1;
      end
    end
    grant = found ? (NREQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/fsqrt_arbiter.sv
// Shares one fsqrt unit among NREQ requesters: round-robin issue, LAT result
// stages, and a held per-requester response slot.
module fsqrt_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_x,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [NREQ*32-1:0] resp_y,
  output logic [NREQ-1:0]   resp_ovf,
  output logic [NREQ-1:0]   resp_udf,
  output logic [NREQ-1:0]   busy
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic             found;

  fp32_t            inX;
  logic [TAG_W-1:0] inTag;
  logic             inValid;

  fp32_t       sqY;
  logic        sqOvf;
  logic        sqUdf;
  sqrt_stage_t head;
  sqrt_stage_t tail;

  assign eligible  = req_valid & ~busy;
  assign req_ready = grant & {NREQ{~rst}};

  rr_grant #(.NREQ(NREQ), .IDX_W(IDX_W)) u_grant (
    .eligible(eligible),
    .ptr     (ptr),
    .grant   (grant),
    .winner  (winner),
    .found   (found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inX     <= '0;
      inTag   <= '0;
      inValid <= 1'b0;
    end else begin
      inValid <= found;
      if (found) begin
        inX   <= req_x[winner*32 +: 32];
        inTag <= TAG_W'(winner);
      end
    end
  end

  fsqrt u_fsqrt (
    .x  (inX),
    .y  (sqY),
    .ovf(sqOvf),
    .udf(sqUdf)
  );

  assign head = '{y: sqY, ovf: sqOvf, udf: sqUdf, tag: inTag, valid: inValid};

  if (LAT == 1) begin : g_direct
    assign tail = head;
  end else begin : g_pipe
    sqrt_stage_t pipe [LAT-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < LAT - 1; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= head;
        for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
      end
    end

    assign tail = pipe[LAT-2];
  end

  // A slot being consumed is never the one a result lands in, and the issuing
  // requester is never busy, so these updates never target the same bit twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= '0;
      resp_y     <= '0;
      resp_ovf   <= '0;
      resp_udf   <= '0;
      busy       <= '0;
      ptr        <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
          busy[i]       <= 1'b0;
        end
        if (tail.valid && tail.tag == TAG_W'(i)) begin
          resp_valid[i]       <= 1'b1;
          resp_y[32*i +: 32]  <= tail.y;
          resp_ovf[i]         <= tail.ovf;
          resp_udf[i]         <= tail.udf;
        end
      end
      if (found) begin
        busy[winner] <= 1'b1;
        ptr          <= (winner == IDX_W'(NREQ - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Randomized bench for fsqrt_arbiter against a queue-based model that uses real-valued sqrt.
module tb_fsqrt_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_x = '0;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready = '0;
  logic [NREQ*32-1:0] resp_y;
  logic [NREQ-1:0]    resp_ovf;
  logic [NREQ-1:0]    resp_udf;
  logic [NREQ-1:0]    busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          rem;
    int          tag;
    logic [33:0] res;
  } flight_t;

  int              mPtr;
  logic [NREQ-1:0] mBusy;
  logic [NREQ-1:0] mRv;
  logic [NREQ-1:0] mOvf;
  logic [NREQ-1:0] mUdf;
  logic [31:0]     mY [NREQ];
  flight_t         inflight [$];

  logic [31:0] laneX [NREQ];
  bit          randX = 1'b1;

  always #5 clk = ~clk;

  fsqrt_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_y    (resp_y),
    .resp_ovf  (resp_ovf),
    .resp_udf  (resp_udf),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference sqrt: exact double-precision sqrt, then one RNE rounding to single.
  function automatic logic [33:0] refSqrt(input logic [31:0] x);
    logic [63:0] db;
    logic [63:0] rb;
    logic [31:0] y;
    logic        rnd;
    if (x[30:23] == 8'hFF && x[22:0] != 0) return {32'h7FC00000, 2'b00};
    if (x[30:23] == 8'h00) return {x[31], 31'b0, 1'b0, x[22:0] != 0};
    if (x[31]) return {32'h7FC00000, 2'b00};
    if (x[30:23] == 8'hFF) return {32'h7F800000, 2'b10};
    db  = {1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
    rb  = $realtobits($sqrt($bitstoreal(db)));
    rnd = rb[28] & ((rb[27:0] != 0) | rb[29]);
    y   = {1'b0, 8'(rb[62:52] - 11'd896), rb[51:29]} + 32'(rnd);
    return {y, 2'b00};
  endfunction

  function automatic logic [31:0] randOperand();
    int          k;
    logic [31:0] r;
    k = $urandom_range(0, 15);
    r = $urandom;
    case (k)
      0:       return {r[31], 31'b0};
      1:       return {r[31], 8'h00, r[22:0] | 23'h1};
      2:       return {1'b1, 8'($urandom_range(1, 254)), r[22:0]};
      3:       return 32'h7F800000;
      4:       return {r[31], 8'hFF, r[22:0] | 23'h1};
      default: return {1'b0, 8'($urandom_range(1, 254)), r[22:0]};
    endcase
  endfunction

  function automatic int expGrant(input logic [NREQ-1:0] v);
    for (int off = 0; off < NREQ; off++) begin
      int idx = (mPtr + off) % NREQ;
      if (v[idx] && !mBusy[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mPtr  = 0;
    mBusy = '0;
    mRv   = '0;
    mOvf  = '0;
    mUdf  = '0;
    for (int i = 0; i < NREQ; i++) mY[i] = '0;
    inflight.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_ovf"}, 32'(resp_ovf), 32'h0);
    checkOutput({tag, "_udf"}, 32'(resp_udf), 32'h0);
    for (int i = 0; i < NREQ; i++)
      checkOutput($sformatf("%s_y%0d", tag, i), resp_y[32*i +: 32], 32'h0);
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance the model after the edge.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr);
    int              g;
    logic [NREQ-1:0] expReady;
    req_valid  = v;
    resp_ready = rr;
    for (int i = 0; i < NREQ; i++) req_x[32*i +: 32] = randX ? randOperand() : laneX[i];
    @(negedge clk);
    g        = expGrant(v);
    expReady = (g >= 0) ? (NREQ'(1) << g) : '0;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    checkOutput("busy", 32'(busy), 32'(mBusy));
    checkOutput("resp_valid", 32'(resp_valid), 32'(mRv));
    checkOutput("resp_ovf", 32'(resp_ovf), 32'(mOvf));
    checkOutput("resp_udf", 32'(resp_udf), 32'(mUdf));
    for (int i = 0; i < NREQ; i++)
      checkOutput($sformatf("resp_y%0d", i), resp_y[32*i +: 32], mY[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (mRv[i] && rr[i]) begin
        mRv[i]   = 1'b0;
        mBusy[i] = 1'b0;
      end
    end
    for (int k = inflight.size() - 1; k >= 0; k--) begin
      inflight[k].rem--;
      if (inflight[k].rem == 0) begin
        mRv[inflight[k].tag]  = 1'b1;
        mY[inflight[k].tag]   = inflight[k].res[33:2];
        mOvf[inflight[k].tag] = inflight[k].res[1];
        mUdf[inflight[k].tag] = inflight[k].res[0];
        inflight.delete(k);
      end
    end
    if (g >= 0) begin
      mBusy[g] = 1'b1;
      mPtr     = (g + 1) % NREQ;
      inflight.push_back('{rem: LAT, tag: g, res: refSqrt(req_x[32*g +: 32])});
    end
  endtask

  initial begin
    modelReset();
    for (int i = 0; i < NREQ; i++) laneX[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("por");
    rst = 1'b0;

    // Single operation: sqrt(4.0) lands LAT edges after the handshake.
    randX    = 1'b0;
    laneX[0] = 32'h40800000;
    applyStimulus(4'b0001, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("sqrt4_y", resp_y[31:0], 32'h40000000);
    checkOutput("sqrt4_valid", 32'(resp_valid), 32'h1);
    checkOutput("sqrt4_busy", 32'(busy), 32'h1);
    applyStimulus(4'b0000, 4'b0001);
    applyStimulus(4'b0000, 4'b0000);

    // Reset one cycle after a handshake, with requests still asserted.
    applyStimulus(4'b0001, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    req_valid = '1;
    rst       = 1'b1;
    #1;
    checkResetState("midrst");
    modelReset();
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (2 * LAT + 2) applyStimulus(4'b0000, 4'b1111);

    // Fairness from ptr=0, then a lone requester 2 wins at once.
    for (int i = 0; i < NREQ; i++) laneX[i] = 32'h40000000 + 32'(i << 20);
    repeat (4) applyStimulus(4'b1111, 4'b1111);
    repeat (LAT + 2) applyStimulus(4'b0000, 4'b1111);
    applyStimulus(4'b0100, 4'b1111);
    repeat (LAT + 2) applyStimulus(4'b0000, 4'b1111);

    // Two requesters continuously valid: alternating grants and collisions.
    laneX[0] = 32'h41100000;
    laneX[1] = 32'h3F800000;
    repeat (16) applyStimulus(4'b0011, 4'b0011);

    // Backpressure on requester 1 while the others keep issuing.
    randX = 1'b1;
    repeat (10) applyStimulus(4'b1111, 4'b1101);
    repeat (6) applyStimulus(4'b1111, 4'b1111);

    // Randomized traffic.
    repeat (500) applyStimulus(NREQ'($urandom), NREQ'($urandom | $urandom));
    repeat (LAT + 3) applyStimulus(4'b0000, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
